aclk_keypad_scanner: RTL and testbench
======================================

Name: aclk_keypad_scanner

Overview:
- Scans the alarm clock's 4x3 matrix keypad, debounces presses and releases, and encodes the pressed digit onto the 4-bit key bus.
- Produces the key code consumed by the alarm clock controller: 0-9 while a digit is held, NOKEY (10) otherwise.
- Sits between the keypad pins and the controller. Same clock domain as the controller.

Parameters:
- SCAN_DIV, 1000: clk cycles per scan tick. Must be >= 4 so the row is settled and synchronised before sampling.
- DEBOUNCE_CNT, 20: consecutive matching scan ticks needed to accept a press or a release. Must be >= 1.
- NOKEY, 10: key code driven when no valid digit is held.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- col  input  3  keypad column sense, active-high, asynchronous to clk
- row  output  4  keypad row drive, one-hot, active-high
- key  output  4  debounced key code: 0-9, or NOKEY
- key_strobe  output  1  one-cycle pulse when a new debounced key is accepted

Behaviour:
- Reset (synchronous, on a clk edge with reset=1):
  - row=4'b0001, key=NOKEY, key_strobe=0
  - state=SCAN, prescaler=0, debounce count=0, both synchroniser stages=0
- col passes through a 2-flop synchroniser. All decisions use the synchronised value colS.
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick=1 in the cycle where prescaler==SCAN_DIV-1. All FSM decisions happen only on tick.
- Key map (row,col):
  - r0: 1,2,3
  - r1: 4,5,6
  - r2: 7,8,9
  - r3: *,0,#
  - * and # are invalid and treated as no key.
- A pattern is valid when colS is exactly one-hot and the (row,col) position maps to a digit. Zero or multiple columns high count as no key (ghost rejection).
- SCAN:
  - On tick with a valid pattern: latch row index and colS, set count=0, go to DEBOUNCE. row stays frozen.
  - On tick otherwise: rotate row left (0001->0010->0100->1000->0001).
- DEBOUNCE (row frozen):
  - On tick with colS == latched pattern: count++.
  - When count reaches DEBOUNCE_CNT: key<=code, key_strobe=1 for one cycle, go to PRESSED.
  - On tick with colS != latched pattern: go to SCAN, row rotates on that tick, key unchanged (NOKEY).
- PRESSED (row frozen, key held):
  - On tick with colS==0: count=0, go to RELEASE.
  - Any nonzero colS, including a different column, keeps PRESSED. No rollover: a second key is ignored until full release.
- RELEASE (row frozen, key still held):
  - On tick with colS==0: count++.
  - When count reaches DEBOUNCE_CNT: key<=NOKEY, rotate row, go to SCAN.
  - On tick with colS!=0: count=0, go back to PRESSED. No strobe, key unchanged.
- Latency:
  - Press to key valid: 2 sync cycles, plus wait for the row's turn, plus (DEBOUNCE_CNT+1) ticks.
  - Release to NOKEY: 2 sync cycles plus (DEBOUNCE_CNT+1) ticks.
- key_strobe is never asserted outside the DEBOUNCE->PRESSED transition.
- key changes only on that transition and on the RELEASE->SCAN transition.
- key never carries 11-15.
- Reset asserted in any state returns everything to reset values on the next edge. A held key is then re-detected from SCAN as a fresh press.

Test Plan:
- (SCAN_DIV=4, DEBOUNCE_CNT=3 for all.) Reset, no press, run 64 cycles -> row cycles 0001,0010,0100,1000 every 4 clk; key=10; key_strobe=0 throughout.
- Hold col=3'b010 whenever row=0010 (digit 5), stable -> key=5 and a single key_strobe pulse exactly 3 ticks (12 clk) after the detection tick. row stays 0010 while held.
- Release the digit 5 key -> key stays 5 for 3 clean ticks after colS drops, then key=10 and row rotates to 0100. Add a 1-tick glitch back high during RELEASE -> return to PRESSED, no strobe, key stays 5.
- Bounce during press: colS matches for 1 tick, drops for 1 tick -> back to SCAN, key=10, no strobe. Then a stable press of row3/col1 -> key=0.
- Press * (row3,col0), press #, and press col=3'b011 on row0 -> key=10, no strobe, scanning continues.
- Digit 9 in PRESSED, assert reset for 1 cycle while still held -> next edge key=10, row=0001. Digit 9 is re-accepted with a fresh strobe after re-scan plus debounce.

Source files
------------

// File: rtl/aclk_keypad_scanner.sv
// 4x3 keypad scanner: rotates one-hot row drive, debounces press/release, emits digit 0-9 or NOKEY.
// Latency: press is seen 2 sync cycles plus DEBOUNCE_CNT+1 scan ticks after its row is driven; there is no backpressure.
module aclk_keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20,
  parameter int NOKEY        = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_strobe
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
  localparam logic [3:0]    NOKEY_CODE = 4'(NOKEY);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state;
  logic [2:0]    col_meta;
  logic [2:0]    col_s;
  logic [2:0]    col_lat;
  logic [PW-1:0] presc;
  logic [CW-1:0] cnt;
  logic [1:0]    row_idx;
  logic          tick;
  logic          valid;
  logic [1:0]    col_idx;
  logic          col_one;
  logic [3:0]    code;

  assign tick = (presc == PRESC_MAX);

  // Multi-column patterns decode as invalid, which rejects ghosted presses.
  always_comb begin
    col_idx = 2'd0;
    col_one = 1'b1;
    case (col_s)
      3'b001:  col_idx = 2'd0;
      3'b010:  col_idx = 2'd1;
      3'b100:  col_idx = 2'd2;
      default: col_one = 1'b0;
    endcase
  end

  always_comb begin
    code  = NOKEY_CODE;
    valid = 1'b0;
    if (col_one) begin
      if (row_idx != 2'd3) begin
        code  = ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx} + 4'd1;
        valid = 1'b1;
      end else if (col_idx == 2'd1) begin
        code  = 4'd0;
        valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SCAN;
      row        <= 4'b0001;
      row_idx    <= 2'd0;
      key        <= NOKEY_CODE;
      key_strobe <= 1'b0;
      presc      <= '0;
      cnt        <= '0;
      col_meta   <= 3'b000;
      col_s      <= 3'b000;
      col_lat    <= 3'b000;
    end else begin
      col_meta   <= col;
      col_s      <= col_meta;
      presc      <= tick ? '0 : presc + PW'(1);
      key_strobe <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (valid) begin
              col_lat <= col_s;
              cnt     <= '0;
              state   <= DEBOUNCE;
            end else begin
              row     <= {row[2:0], row[3]};
              row_idx <= row_idx + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (col_s == col_lat) begin
              if (cnt == CNT_LAST) begin
                key        <= code;
                key_strobe <= 1'b1;
                state      <= PRESSED;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              row     <= {row[2:0], row[3]};
              row_idx <= row_idx + 2'd1;
              state   <= SCAN;
            end
          end
          PRESSED: begin
            if (col_s == 3'b000) begin
              cnt   <= '0;
              state <= RELEASE;
            end
          end
          RELEASE: begin
            if (col_s == 3'b000) begin
              if (cnt == CNT_LAST) begin
                key     <= NOKEY_CODE;
                row     <= {row[2:0], row[3]};
                row_idx <= row_idx + 2'd1;
                state   <= SCAN;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              cnt   <= '0;
              state <= PRESSED;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Bench: a keypad model drives col from the DUT's row; a tick-level reference model is compared every cycle.
module tb_aclk_keypad_scanner;
  localparam int SDIV  = 4;
  localparam int DCNT  = 3;
  localparam int NOKEY = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  col;
  logic [3:0]  row;
  logic [3:0]  key;
  logic        key_strobe;
  logic [11:0] held;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int strobe_cnt = 0;

  aclk_keypad_scanner #(.SCAN_DIV(SDIV), .DEBOUNCE_CNT(DCNT), .NOKEY(NOKEY)) dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .key(key), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key connects its row line to its column line.
  always_comb begin
    col = 3'b000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (row[r] && held[r*3+c]) col[c] = 1'b1;
  end

  always @(posedge clk) begin
    if (!reset) ecount <= ecount + 1;
    if (key_strobe) strobe_cnt <= strobe_cnt + 1;
  end

  // Reference model, evaluated in units of scan ticks.
  int keymap [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{-1, 0, -1}};
  localparam int P_SCAN = 0, P_DEB = 1, P_HELD = 2, P_REL = 3;
  int         m_div, m_ridx, m_phase, m_cnt, m_key;
  logic [2:0] m_s1, m_s2, m_lat;
  bit         m_strobe;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    int n_div, n_ridx, n_phase, n_cnt, n_key, code;
    logic [2:0] n_lat;
    bit n_strobe;
    if (reset) begin
      m_div <= 0; m_ridx <= 0; m_phase <= P_SCAN; m_cnt <= 0; m_key <= NOKEY;
      m_s1 <= 3'b000; m_s2 <= 3'b000; m_lat <= 3'b000; m_strobe <= 1'b0; m_valid <= 1'b1;
    end else begin
      n_div = (m_div + 1) % SDIV;
      n_ridx = m_ridx; n_phase = m_phase; n_cnt = m_cnt; n_key = m_key; n_lat = m_lat;
      n_strobe = 1'b0;
      code = -1;
      if ($countones(m_s2) == 1)
        for (int c = 0; c < 3; c++) if (m_s2[c]) code = keymap[m_ridx][c];
      if (m_div == SDIV - 1) begin
        if (m_phase == P_SCAN) begin
          if (code >= 0) begin n_phase = P_DEB; n_lat = m_s2; n_cnt = 0; end
          else n_ridx = (m_ridx + 1) % 4;
        end else if (m_phase == P_DEB) begin
          if (m_s2 != m_lat) begin n_phase = P_SCAN; n_ridx = (m_ridx + 1) % 4; end
          else begin
            n_cnt = m_cnt + 1;
            if (n_cnt == DCNT) begin n_key = code; n_strobe = 1'b1; n_phase = P_HELD; end
          end
        end else if (m_phase == P_HELD) begin
          if (m_s2 == 3'b000) begin n_phase = P_REL; n_cnt = 0; end
        end else begin
          if (m_s2 != 3'b000) begin n_phase = P_HELD; n_cnt = 0; end
          else begin
            n_cnt = m_cnt + 1;
            if (n_cnt == DCNT) begin n_key = NOKEY; n_ridx = (m_ridx + 1) % 4; n_phase = P_SCAN; end
          end
        end
      end
      m_div <= n_div; m_ridx <= n_ridx; m_phase <= n_phase; m_cnt <= n_cnt; m_key <= n_key;
      m_lat <= n_lat; m_strobe <= n_strobe; m_s2 <= m_s1; m_s1 <= col;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, ecount, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_row", int'(row), 1 << m_ridx);
      check("model_key", int'(key), m_key);
      check("model_strobe", int'(key_strobe), int'(m_strobe));
    end
  end

  task automatic goto(input int e);
    while (ecount < e) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    held  = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_row", int'(row), 1);
    check("reset_key", int'(key), 10);
    check("reset_strobe", int'(key_strobe), 0);
    reset = 1'b0;

    // Idle scanning: 16 rotations brings row back to 0001.
    goto(64);
    check("idle_row", int'(row), 1);
    check("idle_key", int'(key), 10);
    check("idle_strobes", strobe_cnt, 0);

    // Digit 5 (row1,col1): detected at edge 72, accepted 12 clk later.
    held[4] = 1'b1;
    goto(83);
    check("d5_pre_key", int'(key), 10);
    check("d5_pre_strobe", int'(key_strobe), 0);
    goto(84);
    check("d5_strobe", int'(key_strobe), 1);
    check("d5_key", int'(key), 5);
    goto(85);
    check("d5_strobe_one_cycle", int'(key_strobe), 0);
    goto(99);
    check("d5_row_frozen", int'(row), 2);

    // Clean release.
    goto(100);
    held[4] = 1'b0;
    goto(115);
    check("rel_key_held", int'(key), 5);
    goto(116);
    check("rel_key", int'(key), 10);
    check("rel_row", int'(row), 4);

    // Re-press 5, then a one-tick glitch back high during RELEASE.
    held[4] = 1'b1;
    goto(148);
    held[4] = 1'b0;
    goto(153);
    held[4] = 1'b1;
    goto(157);
    held[4] = 1'b0;
    goto(171);
    check("glitch_key", int'(key), 5);
    check("glitch_strobes", strobe_cnt, 2);
    goto(172);
    check("glitch_rel_key", int'(key), 10);

    // Bounce on digit 0: one matching tick then mismatch aborts.
    held[10] = 1'b1;
    goto(184);
    held[10] = 1'b0;
    goto(190);
    check("bounce_key", int'(key), 10);
    check("bounce_strobes", strobe_cnt, 2);
    check("bounce_row", int'(row), 1);
    held[10] = 1'b1;
    goto(216);
    check("d0_key", int'(key), 0);
    check("d0_strobe", int'(key_strobe), 1);
    goto(220);
    held[10] = 1'b0;

    // Invalid patterns: *, #, and two columns on row0.
    goto(236);
    held[9] = 1'b1;
    goto(256);
    held[9] = 1'b0; held[11] = 1'b1;
    goto(276);
    held[11] = 1'b0; held[0] = 1'b1; held[1] = 1'b1;
    goto(296);
    held[0] = 1'b0; held[1] = 1'b0;
    goto(300);
    check("invalid_key", int'(key), 10);
    check("invalid_strobes", strobe_cnt, 3);
    check("invalid_row", int'(row), 1);

    // Digit 9, then reset while held.
    held[8] = 1'b1;
    goto(324);
    check("d9_key", int'(key), 9);
    check("d9_strobe", int'(key_strobe), 1);
    goto(330);
    reset = 1'b1;
    @(negedge clk);
    check("rst_held_key", int'(key), 10);
    check("rst_held_row", int'(row), 1);
    reset = 1'b0;
    goto(353);
    check("d9_again_pre", int'(key), 10);
    goto(354);
    check("d9_again_strobe", int'(key_strobe), 1);
    check("d9_again_key", int'(key), 9);
    goto(360);
    held[8] = 1'b0;
    goto(400);
    check("final_key", int'(key), 10);
    check("final_strobes", strobe_cnt, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
